// File: rtl/gbc_frame_upscaler_pkg.sv
// Shared GBC video constants and the RGB332 pixel layout used along the display path.
package gbc_frame_upscaler_pkg;

  localparam int GBC_H_PIXELS    = 160;
  localparam int GBC_V_PIXELS    = 144;
  localparam int VRAM_ADDR_WIDTH = 15;

  localparam int RGB_RED_LSB   = 5;
  localparam int RGB_GREEN_LSB = 2;
  localparam int RGB_BLUE_LSB  = 0;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } rgb332_t;

  function automatic rgb332_t to_rgb332(input logic [7:0] raw);
    rgb332_t px;
    px.red   = raw[RGB_RED_LSB +: 3];
    px.green = raw[RGB_GREEN_LSB +: 3];
    px.blue  = raw[RGB_BLUE_LSB +: 2];
    return px;
  endfunction

endpackage

// File: rtl/gbc_frame_upscaler_if.sv
// Raster-in / VRAM / RGB-out bundle between the timing controller, frame-buffer SRAM and upscaler.
interface gbc_frame_upscaler_if
  import gbc_frame_upscaler_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH
);

  logic                  i_hSync;
  logic                  i_vSync;
  logic                  i_active;
  logic [15:0]           i_x;
  logic [15:0]           i_y;
  logic [ADDR_WIDTH-1:0] o_vramReadAddr;
  logic [7:0]            i_vramData;
  logic                  o_hSync;
  logic                  o_vSync;
  logic [2:0]            o_red;
  logic [2:0]            o_green;
  logic [1:0]            o_blue;

  modport master (
    output i_hSync, i_vSync, i_active, i_x, i_y, i_vramData,
    input  o_vramReadAddr, o_hSync, o_vSync, o_red, o_green, o_blue
  );

  modport slave (
    input  i_hSync, i_vSync, i_active, i_x, i_y, i_vramData,
    output o_vramReadAddr, o_hSync, o_vSync, o_red, o_green, o_blue
  );

endinterface

// File: rtl/gbc_frame_upscaler_delay_line.sv
// Fixed-depth shift register that keeps sync and window flags aligned with the VRAM pipeline.
module gbc_frame_upscaler_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages_q [DEPTH];
  logic [WIDTH-1:0] stages_d [DEPTH];

  always_comb begin
    stages_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stages_d[i] = stages_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stages_q[i] <= stages_d[i];
      end
    end
  end

  assign dout = stages_q[DEPTH-1];

endmodule

// File: rtl/gbc_frame_upscaler.sv
// Integer upscaler from the 160x144 GBC frame buffer onto the 1280x720 raster:
// multiplier-free VRAM address counters plus a 3-stage colour/sync pipeline.
module gbc_frame_upscaler
  import gbc_frame_upscaler_pkg::*;
#(
  parameter int         SRC_W        = GBC_H_PIXELS,
  parameter int         SRC_H        = GBC_V_PIXELS,
  parameter int         SCALE        = 4,
  parameter int         H_OFFSET     = 320,
  parameter int         V_OFFSET     = 72,
  parameter int         ADDR_WIDTH   = VRAM_ADDR_WIDTH,
  parameter logic [7:0] BORDER_COLOR = 8'h00
) (
  input  logic                i_clkPixel,
  input  logic                i_rstN,
  gbc_frame_upscaler_if.slave bus
);

  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int COL_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;

  localparam logic [15:0]           X_FIRST       = 16'(H_OFFSET);
  localparam logic [15:0]           X_LAST        = 16'(H_OFFSET + SRC_W * SCALE - 1);
  localparam logic [15:0]           Y_FIRST       = 16'(V_OFFSET);
  localparam logic [15:0]           Y_LAST        = 16'(V_OFFSET + SRC_H * SCALE - 1);
  localparam logic [SUB_W-1:0]      SUB_LAST      = SUB_W'(SCALE - 1);
  localparam logic [COL_W-1:0]      COL_LAST      = COL_W'(SRC_W - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP      = ADDR_WIDTH'(SRC_W);
  localparam logic [ADDR_WIDTH-1:0] ROW_BASE_LAST = ADDR_WIDTH'((SRC_H - 1) * SRC_W);

  logic                  in_win_row;
  logic                  in_win;
  logic                  row_end;

  logic [SUB_W-1:0]      h_sub_q, h_sub_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [SUB_W-1:0]      v_sub_q, v_sub_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  rgb332_t               rgb_q, rgb_d;

  logic                  win2;
  logic                  act2;
  logic [1:0]            sync_dly;

  assign in_win_row = (bus.i_y >= Y_FIRST) && (bus.i_y <= Y_LAST);
  assign in_win     = bus.i_active && in_win_row && (bus.i_x >= X_FIRST) && (bus.i_x <= X_LAST);
  assign row_end    = in_win && (bus.i_x == X_LAST);

  // Counters track the current source pixel/row; the address only moves while inside the window.
  always_comb begin
    h_sub_d    = h_sub_q;
    col_d      = col_q;
    v_sub_d    = v_sub_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;

    if (in_win) begin
      addr_d = row_base_q + ADDR_WIDTH'(col_q);
      if (h_sub_q == SUB_LAST) begin
        h_sub_d = '0;
        col_d   = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
      end else begin
        h_sub_d = h_sub_q + SUB_W'(1);
      end
    end else begin
      h_sub_d = '0;
      col_d   = '0;
    end

    // The last window row wraps rowBase back to 0 instead of stepping past the frame.
    if (!in_win_row) begin
      v_sub_d    = '0;
      row_base_d = '0;
    end else if (row_end) begin
      if (v_sub_q == SUB_LAST) begin
        v_sub_d    = '0;
        row_base_d = (row_base_q == ROW_BASE_LAST) ? '0 : row_base_q + ROW_STEP;
      end else begin
        v_sub_d = v_sub_q + SUB_W'(1);
      end
    end
  end

  always_comb begin
    rgb_d = '0;
    if (win2) begin
      rgb_d = to_rgb332(bus.i_vramData);
    end else if (act2) begin
      rgb_d = to_rgb332(BORDER_COLOR);
    end
  end

  always_ff @(posedge i_clkPixel) begin
    if (!i_rstN) begin
      h_sub_q    <= '0;
      col_q      <= '0;
      v_sub_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      rgb_q      <= '0;
    end else begin
      h_sub_q    <= h_sub_d;
      col_q      <= col_d;
      v_sub_q    <= v_sub_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      rgb_q      <= rgb_d;
    end
  end

  // Window/active flags need two stages to meet the SRAM data; syncs need all three.
  gbc_frame_upscaler_delay_line #(
    .WIDTH(2),
    .DEPTH(2)
  ) u_flag_delay (
    .clk  (i_clkPixel),
    .rst_n(i_rstN),
    .din  ({in_win, bus.i_active}),
    .dout ({win2, act2})
  );

  gbc_frame_upscaler_delay_line #(
    .WIDTH(2),
    .DEPTH(3)
  ) u_sync_delay (
    .clk  (i_clkPixel),
    .rst_n(i_rstN),
    .din  ({bus.i_hSync, bus.i_vSync}),
    .dout (sync_dly)
  );

  assign bus.o_vramReadAddr = addr_q;
  assign bus.o_hSync        = sync_dly[1];
  assign bus.o_vSync        = sync_dly[0];
  assign bus.o_red          = rgb_q.red;
  assign bus.o_green        = rgb_q.green;
  assign bus.o_blue         = rgb_q.blue;

endmodule

// File: tb/tb_gbc_frame_upscaler.sv
// Randomised raster bench for gbc_frame_upscaler against an arithmetic (divide/multiply) reference model.
module tb_gbc_frame_upscaler;

  localparam int         SRC_W    = 160;
  localparam int         SRC_H    = 144;
  localparam int         SCALE    = 4;
  localparam int         H_OFF    = 320;
  localparam int         V_OFF    = 72;
  localparam int         VRAM_LEN = SRC_W * SRC_H;
  localparam logic [7:0] BORDER   = 8'h1C;

  typedef struct {
    bit          rst_n;
    bit          addr_chk;
    logic [14:0] addr;
    bit          rgb_chk;
    logic [7:0]  rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic       clk;
  logic       i_rstN;
  logic [7:0] vram [VRAM_LEN];

  exp_t hist [8];
  int   pix_cnt;
  int   checks;
  int   errors;
  bit   frame_ok;
  bit   addr_ok;
  int   last_addr;

  gbc_frame_upscaler_if #(.ADDR_WIDTH(15)) bus ();

  gbc_frame_upscaler #(
    .SRC_W       (SRC_W),
    .SRC_H       (SRC_H),
    .SCALE       (SCALE),
    .H_OFFSET    (H_OFF),
    .V_OFFSET    (V_OFF),
    .ADDR_WIDTH  (15),
    .BORDER_COLOR(BORDER)
  ) dut (
    .i_clkPixel(clk),
    .i_rstN    (i_rstN),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame-buffer SRAM: registered read, data one cycle after the address.
  always @(posedge clk) begin
    bus.i_vramData <= vram[int'(bus.o_vramReadAddr) % VRAM_LEN];
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h pixel=%0d", tag, actual, expected, pix_cnt);
    end
  endtask

  // Each call checks earlier pixels whose results are now due, then presents one new pixel.
  task automatic apply_stimulus(input int x, input int y, input bit act, input bit full, input bit rst_n);
    exp_t e;
    bit   flush;
    bit   in_row;
    bit   in_win;
    int   a;
    @(negedge clk);
    if (pix_cnt >= 1) begin
      e = hist[(pix_cnt - 1) % 8];
      if (e.addr_chk) check_output("addr", 32'(bus.o_vramReadAddr), 32'(e.addr));
    end
    if (pix_cnt >= 3) begin
      e     = hist[(pix_cnt - 3) % 8];
      flush = !e.rst_n || !hist[(pix_cnt - 2) % 8].rst_n || !hist[(pix_cnt - 1) % 8].rst_n;
      if (flush || e.rgb_chk)
        check_output("rgb", 32'({bus.o_red, bus.o_green, bus.o_blue}), flush ? 32'd0 : 32'(e.rgb));
      check_output("hsync", 32'(bus.o_hSync), flush ? 32'd0 : 32'(e.hs));
      check_output("vsync", 32'(bus.o_vSync), flush ? 32'd0 : 32'(e.vs));
    end

    bus.i_x      = 16'(x);
    bus.i_y      = 16'(y);
    bus.i_active = act;
    bus.i_hSync  = 1'($urandom_range(0, 1));
    bus.i_vSync  = 1'($urandom_range(0, 1));
    i_rstN       = rst_n;

    e.rst_n    = rst_n;
    e.hs       = bus.i_hSync;
    e.vs       = bus.i_vSync;
    e.addr_chk = 1'b0;
    e.addr     = '0;
    e.rgb_chk  = 1'b0;
    e.rgb      = '0;
    in_row     = (y >= V_OFF) && (y < V_OFF + SRC_H * SCALE);
    in_win     = act && in_row && (x >= H_OFF) && (x < H_OFF + SRC_W * SCALE);

    if (!rst_n) begin
      e.addr_chk = 1'b1;
      last_addr  = 0;
      addr_ok    = 1'b1;
      frame_ok   = 1'b0;
    end else if (in_win) begin
      if (frame_ok && full) begin
        a          = ((y - V_OFF) / SCALE) * SRC_W + (x - H_OFF) / SCALE;
        e.addr_chk = 1'b1;
        e.addr     = 15'(a);
        e.rgb_chk  = 1'b1;
        e.rgb      = vram[a];
        last_addr  = a;
        addr_ok    = 1'b1;
      end else begin
        addr_ok = 1'b0;
      end
    end else begin
      e.addr_chk = addr_ok;
      e.addr     = 15'(last_addr);
      e.rgb_chk  = 1'b1;
      e.rgb      = act ? BORDER : 8'h00;
      if (!in_row) frame_ok = 1'b1;
    end

    hist[pix_cnt % 8] = e;
    pix_cnt++;
  endtask

  // Full rows scan every window column; fast rows present only the row-ending pixel.
  task automatic scan_row(input int y, input bit full, input int reset_x);
    int nm;
    nm = $urandom_range(1, 3);
    for (int i = 0; i < nm; i++) begin
      apply_stimulus((y == 100 && i == 0) ? 100 : $urandom_range(0, 315), y,
                     (y == 100 && i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    if (full) begin
      for (int x = 316; x <= 963; x++) begin
        apply_stimulus(x, y, 1'b1, 1'b1, !((reset_x >= 0) && (x >= reset_x) && (x < reset_x + 3)));
      end
      apply_stimulus(600, y, 1'b0, 1'b1, 1'b1);
      apply_stimulus($urandom_range(964, 1279), y, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end else begin
      apply_stimulus(959, y, 1'b1, 1'b0, 1'b1);
    end
  endtask

  task automatic run_frame(input int reset_y);
    bit full;
    int y;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus($urandom_range(0, 1279), 20 + i, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    for (int r = 0; r < SRC_H * SCALE; r++) begin
      y    = V_OFF + r;
      full = (r < 6) || (r >= SRC_H * SCALE - 6) || (y == reset_y) || ($urandom_range(0, 199) == 0);
      scan_row(y, full, (y == reset_y) ? 500 : -1);
      if ((reset_y >= 0) && (y >= reset_y + 4)) break;
    end
    for (int x = 320; x < 328; x++) begin
      apply_stimulus(x, V_OFF + SRC_H * SCALE, 1'b1, 1'b1, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      apply_stimulus($urandom_range(0, 1279), 700 + i, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    i_rstN         = 1'b0;
    bus.i_x        = '0;
    bus.i_y        = '0;
    bus.i_active   = 1'b0;
    bus.i_hSync    = 1'b0;
    bus.i_vSync    = 1'b0;
    pix_cnt        = 0;
    checks         = 0;
    errors         = 0;
    frame_ok       = 1'b0;
    addr_ok        = 1'b0;
    last_addr      = 0;
    for (int i = 0; i < VRAM_LEN; i++) vram[i] = 8'($urandom_range(0, 255));
    vram[0] = 8'hE3;

    $display("[TB] reset with controller running");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus($urandom_range(300, 700), $urandom_range(60, 200), 1'b1, 1'b0, 1'b0);
    end

    $display("[TB] clean frame");
    run_frame(-1);
    $display("[TB] frame with reset inside the window");
    run_frame(300);
    $display("[TB] recovery frame");
    run_frame(-1);

    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
